// File: rtl/ft601_bus_ctrl.sv
// FT601 245-synchronous FIFO bus sequencer: arbitrates RX/TX bursts on the
// half-duplex bus, inserts turnaround cycles and releases the FT601 reset.
module ft601_bus_ctrl #(
  parameter int MaxBurst      = 256,
  parameter int RstHoldCycles = 16
) (
  input  logic        usb_clk_i,
  input  logic        usb_rst_ni,
  input  logic [31:0] usb_data_i,
  output logic [31:0] usb_data_o,
  output logic        usb_data_oe,
  output logic [3:0]  usb_be_o,
  output logic        usb_be_oe,
  input  logic        usb_rxf_ni,
  input  logic        usb_txe_ni,
  output logic        usb_rd_no,
  output logic        usb_wr_no,
  output logic        usb_oe_no,
  output logic        usb_siwu_no,
  output logic        usb_rst_no,
  output logic        rx_valid_o,
  output logic [31:0] rx_data_o,
  input  logic        rx_afull_i,
  input  logic        tx_valid_i,
  input  logic [31:0] tx_data_i,
  input  logic [3:0]  tx_be_i,
  output logic        tx_ready_o,
  output logic        busy_o,
  output logic [2:0]  state_o
);

  localparam int CW = $clog2(MaxBurst + 1);
  localparam int HW = $clog2(RstHoldCycles + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MaxBurst);
  localparam logic [CW-1:0] CNT_LAST = CW'(MaxBurst - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RstHoldCycles - 1);

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_IDLE     = 3'd1,
    S_RX_OE    = 3'd2,
    S_RX_BURST = 3'd3,
    S_RX_END   = 3'd4,
    S_TX_BURST = 3'd5,
    S_TURN     = 3'd6
  } state_t;

  state_t        r_state, w_state_next;
  logic [HW-1:0] r_hold, w_hold_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_last_rx, w_last_rx_next;

  logic          w_rx_ok, w_tx_ok;
  logic [CW-1:0] w_cnt_inc;

  assign w_rx_ok   = !usb_rxf_ni && !rx_afull_i;
  assign w_tx_ok   = !usb_txe_ni && tx_valid_i;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge usb_clk_i or negedge usb_rst_ni) begin
    if (!usb_rst_ni) begin
      r_state   <= S_RESET;
      r_hold    <= '0;
      r_cnt     <= '0;
      r_last_rx <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_cnt     <= w_cnt_next;
      r_last_rx <= w_last_rx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_cnt_next     = r_cnt;
    w_last_rx_next = r_last_rx;
    usb_rd_no      = 1'b1;
    usb_wr_no      = 1'b1;
    usb_oe_no      = 1'b1;
    usb_data_oe    = 1'b0;
    usb_be_oe      = 1'b0;
    usb_data_o     = '0;
    usb_be_o       = '0;
    rx_valid_o     = 1'b0;
    tx_ready_o     = 1'b0;

    unique case (r_state)
      S_RESET: begin
        if (r_hold == HOLD_LAST) w_state_next = S_IDLE;
        else                     w_hold_next  = r_hold + HW'(1);
      end
      S_IDLE: begin
        // On contention the direction not served last wins.
        if (w_rx_ok && (!w_tx_ok || !r_last_rx)) begin
          w_state_next   = S_RX_OE;
          w_last_rx_next = 1'b1;
          w_cnt_next     = '0;
        end else if (w_tx_ok) begin
          w_state_next   = S_TX_BURST;
          w_last_rx_next = 1'b0;
          w_cnt_next     = '0;
        end
      end
      S_RX_OE: begin
        usb_oe_no    = 1'b0;
        w_state_next = S_RX_BURST;
      end
      S_RX_BURST: begin
        usb_oe_no = 1'b0;
        usb_rd_no = rx_afull_i;
        if (w_rx_ok) begin
          rx_valid_o = 1'b1;
          w_cnt_next = w_cnt_inc;
        end
        if (!w_rx_ok || (r_cnt == CNT_LAST)) w_state_next = S_RX_END;
      end
      S_RX_END: w_state_next = S_TURN;
      S_TX_BURST: begin
        usb_data_oe = 1'b1;
        usb_be_oe   = 1'b1;
        usb_data_o  = tx_data_i;
        usb_be_o    = tx_be_i;
        usb_wr_no   = !w_tx_ok;
        tx_ready_o  = !usb_txe_ni;
        if (w_tx_ok) w_cnt_next = w_cnt_inc;
        if (!w_tx_ok || (r_cnt == CNT_LAST)) w_state_next = S_TURN;
      end
      S_TURN:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign rx_data_o   = usb_data_i;
  assign usb_rst_no  = (r_state != S_RESET);
  assign usb_siwu_no = 1'b1;
  assign busy_o      = (r_state != S_IDLE);
  assign state_o     = r_state;

endmodule

// File: tb/tb_ft601_bus_ctrl.sv
// Directed bench for ft601_bus_ctrl: FT601 and stream peers built from queues,
// a burst-budget model checked every cycle, plus literal scenario checks.
module tb_ft601_bus_ctrl;
  localparam int MB = 4;
  localparam int RH = 16;
  localparam int P_RESET = 0, P_IDLE = 1, P_RXOE = 2, P_RXB = 3, P_RXEND = 4, P_TXB = 5, P_TURN = 6;

  logic        usb_clk_i = 1'b0;
  logic        usb_rst_ni;
  logic [31:0] usb_data_i;
  logic [31:0] usb_data_o;
  logic        usb_data_oe;
  logic [3:0]  usb_be_o;
  logic        usb_be_oe;
  logic        usb_rxf_ni, usb_txe_ni;
  logic        usb_rd_no, usb_wr_no, usb_oe_no, usb_siwu_no, usb_rst_no;
  logic        rx_valid_o;
  logic [31:0] rx_data_o;
  logic        rx_afull_i, tx_valid_i;
  logic [31:0] tx_data_i;
  logic [3:0]  tx_be_i;
  logic        tx_ready_o, busy_o;
  logic [2:0]  state_o;

  ft601_bus_ctrl #(.MaxBurst(MB), .RstHoldCycles(RH)) dut (
    .usb_clk_i(usb_clk_i), .usb_rst_ni(usb_rst_ni),
    .usb_data_i(usb_data_i), .usb_data_o(usb_data_o), .usb_data_oe(usb_data_oe),
    .usb_be_o(usb_be_o), .usb_be_oe(usb_be_oe),
    .usb_rxf_ni(usb_rxf_ni), .usb_txe_ni(usb_txe_ni),
    .usb_rd_no(usb_rd_no), .usb_wr_no(usb_wr_no), .usb_oe_no(usb_oe_no),
    .usb_siwu_no(usb_siwu_no), .usb_rst_no(usb_rst_no),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_afull_i(rx_afull_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_be_i(tx_be_i),
    .tx_ready_o(tx_ready_o), .busy_o(busy_o), .state_o(state_o)
  );

  always #5 usb_clk_i = ~usb_clk_i;

  int vectors = 0;
  int miscompares = 0;

  // model: phase plus remaining reset-hold and burst budgets
  int m_ph, m_hold_left, m_words_left;
  bit m_last_rx;
  int n_ph, n_hold_left, n_words_left;
  bit n_last_rx;
  bit pop_rx, pop_src;

  logic [31:0] ft_rx_q[$];
  logic [35:0] src_q[$];
  logic [31:0] rx_got[$];
  logic [35:0] ft_tx_got[$];
  int          tx_runs[$];
  int          grants[$];
  int cyc = 0, first_oe = -1, first_rd = -1, wr_run = 0, prev_state = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph = P_RESET; m_hold_left = RH; m_last_rx = 1'b0; m_words_left = 0;
  endtask

  task automatic drive();
    usb_rxf_ni = (ft_rx_q.size() == 0);
    usb_data_i = (ft_rx_q.size() != 0) ? ft_rx_q[0] : 32'h0;
    tx_valid_i = (src_q.size() != 0);
    {tx_be_i, tx_data_i} = (src_q.size() != 0) ? src_q[0] : 36'h0;
  endtask

  task automatic check_cycle();
    bit rx_ok, tx_ok, txb, rxb;
    bit e_oe_no, e_rd_no, e_wr_no, e_rx_valid, e_tx_ready;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    cyc++;
    if (!usb_rst_ni) model_reset();
    rx_ok = !usb_rxf_ni && !rx_afull_i;
    tx_ok = !usb_txe_ni && tx_valid_i;
    txb = (m_ph == P_TXB);
    rxb = (m_ph == P_RXB);
    e_oe_no    = !(rxb || m_ph == P_RXOE);
    e_rd_no    = rxb ? rx_afull_i : 1'b1;
    e_wr_no    = !(txb && tx_ok);
    e_rx_valid = rxb && rx_ok;
    e_tx_ready = txb && !usb_txe_ni;
    e_data     = txb ? tx_data_i : 32'h0;
    e_be       = txb ? tx_be_i : 4'h0;

    chk("state_o",     36'(state_o),     36'(m_ph));
    chk("usb_rst_no",  36'(usb_rst_no),  36'(m_ph != P_RESET));
    chk("busy_o",      36'(busy_o),      36'(m_ph != P_IDLE));
    chk("usb_rd_no",   36'(usb_rd_no),   36'(e_rd_no));
    chk("usb_wr_no",   36'(usb_wr_no),   36'(e_wr_no));
    chk("usb_oe_no",   36'(usb_oe_no),   36'(e_oe_no));
    chk("usb_data_oe", 36'(usb_data_oe), 36'(txb));
    chk("usb_be_oe",   36'(usb_be_oe),   36'(txb));
    chk("usb_data_o",  36'(usb_data_o),  36'(e_data));
    chk("usb_be_o",    36'(usb_be_o),    36'(e_be));
    chk("rx_valid_o",  36'(rx_valid_o),  36'(e_rx_valid));
    chk("tx_ready_o",  36'(tx_ready_o),  36'(e_tx_ready));
    chk("usb_siwu_no", 36'(usb_siwu_no), 36'(1));
    chk("bus_contention", 36'(usb_data_oe && !usb_oe_no), 36'(0));
    chk("valid_on_afull", 36'(rx_valid_o && rx_afull_i), 36'(0));
    if (e_rx_valid && ft_rx_q.size() != 0) chk("rx_data_o", 36'(rx_data_o), 36'(ft_rx_q[0]));

    // peers react to what the DUT actually drives
    if (rx_valid_o) begin
      rx_got.push_back(rx_data_o);
      $display("cycle %0d rx word %h", cyc, rx_data_o);
    end
    if (!usb_wr_no && !usb_txe_ni) begin
      ft_tx_got.push_back({usb_be_o, usb_data_o});
      $display("cycle %0d tx word %h be %h", cyc, usb_data_o, usb_be_o);
    end
    pop_rx  = usb_rst_ni && !usb_rd_no && !usb_oe_no && !usb_rxf_ni;
    pop_src = usb_rst_ni && tx_ready_o && tx_valid_i;
    if (!usb_oe_no && first_oe < 0) first_oe = cyc;
    if (!usb_rd_no && first_rd < 0) first_rd = cyc;
    if (!usb_wr_no) wr_run++;
    else if (wr_run != 0) begin tx_runs.push_back(wr_run); wr_run = 0; end
    if (state_o == 3'd2 && prev_state != 2) grants.push_back(1);
    if (state_o == 3'd5 && prev_state != 5) grants.push_back(2);
    prev_state = int'(state_o);

    n_ph = m_ph; n_hold_left = m_hold_left; n_words_left = m_words_left; n_last_rx = m_last_rx;
    if (usb_rst_ni) begin
      case (m_ph)
        P_RESET: begin
          n_hold_left = m_hold_left - 1;
          if (n_hold_left == 0) n_ph = P_IDLE;
        end
        P_IDLE: begin
          if (rx_ok && (!tx_ok || !m_last_rx)) begin
            n_ph = P_RXOE; n_last_rx = 1'b1; n_words_left = MB;
          end else if (tx_ok) begin
            n_ph = P_TXB; n_last_rx = 1'b0; n_words_left = MB;
          end
        end
        P_RXOE:  n_ph = P_RXB;
        P_RXB: begin
          if (rx_ok) n_words_left = m_words_left - 1;
          if (!rx_ok || n_words_left == 0) n_ph = P_RXEND;
        end
        P_RXEND: n_ph = P_TURN;
        P_TXB: begin
          if (tx_ok) n_words_left = m_words_left - 1;
          if (!tx_ok || n_words_left == 0) n_ph = P_TURN;
        end
        default: n_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic apply();
    if (!usb_rst_ni) model_reset();
    else begin
      m_ph = n_ph; m_hold_left = n_hold_left; m_words_left = n_words_left; m_last_rx = n_last_rx;
      if (pop_rx && ft_rx_q.size() != 0) ft_rx_q.delete(0);
      if (pop_src && src_q.size() != 0) src_q.delete(0);
    end
    pop_rx = 1'b0;
    pop_src = 1'b0;
  endtask

  task automatic cycle();
    @(negedge usb_clk_i);
    check_cycle();
    @(posedge usb_clk_i);
    #1;
    apply();
    drive();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int k = 0;
    bit done;
    do begin
      cycle();
      k++;
      done = (ft_rx_q.size() == 0 && src_q.size() == 0 && m_ph == P_IDLE);
    end while (!done && k < budget);
    chk(name, 36'(done), 36'(1));
  endtask

  task automatic clear_logs();
    rx_got.delete(); ft_tx_got.delete(); tx_runs.delete(); grants.delete();
    wr_run = 0;
  endtask

  initial begin
    int n;
    usb_rst_ni = 1'b1;
    usb_txe_ni = 1'b1;
    rx_afull_i = 1'b0;
    model_reset();
    drive();
    #1 usb_rst_ni = 1'b0;
    #1;
    chk("reset_rst_no", 36'(usb_rst_no), 36'(0));
    chk("reset_strobes", 36'({usb_rd_no, usb_wr_no, usb_oe_no}), 36'(3'b111));
    chk("reset_oe", 36'({usb_data_oe, usb_be_oe}), 36'(0));
    chk("reset_state", 36'({busy_o, state_o}), 36'(4'b1000));
    cycle();
    cycle();

    // reset release: exactly RH cycles of usb_rst_no low
    usb_rst_ni = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (usb_rst_no !== 1'b1 && n < 64);
    chk("rst_hold_cycles", 36'(n), 36'(16));
    chk("after_hold_state", 36'(state_o), 36'(1));

    // RX only, 10 words in bursts of MB
    clear_logs();
    first_oe = -1; first_rd = -1;
    for (int i = 1; i <= 10; i++) ft_rx_q.push_back(32'(i));
    drive();
    run_until_idle("rx_only_done", 200);
    chk("oe_before_rd", 36'(first_rd - first_oe), 36'(1));
    chk("rx_only_count", 36'(rx_got.size()), 36'(10));
    for (int i = 0; i < rx_got.size() && i < 10; i++) chk("rx_only_data", 36'(rx_got[i]), 36'(i + 1));

    // TX only, 6 words split 4 + 2
    clear_logs();
    usb_txe_ni = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back({4'(4'b0001 << (i % 4)), 32'hA000_0000 + 32'(i)});
    drive();
    run_until_idle("tx_only_done", 200);
    chk("tx_run_count", 36'(tx_runs.size()), 36'(2));
    if (tx_runs.size() == 2) begin
      chk("tx_run0", 36'(tx_runs[0]), 36'(4));
      chk("tx_run1", 36'(tx_runs[1]), 36'(2));
    end
    chk("tx_only_count", 36'(ft_tx_got.size()), 36'(6));
    if (ft_tx_got.size() == 6) begin
      chk("tx_word2", ft_tx_got[2], 36'h4_A000_0002);
      chk("tx_word5", ft_tx_got[5], 36'h2_A000_0005);
    end

    // both directions pending: grants alternate starting with RX
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      ft_rx_q.push_back(32'h31 + 32'(i));
      src_q.push_back({4'hF, 32'hC000_0000 + 32'(i)});
    end
    drive();
    run_until_idle("both_done", 300);
    chk("grant_count", 36'(grants.size() >= 3), 36'(1));
    if (grants.size() >= 3) begin
      chk("grant0_rx", 36'(grants[0]), 36'(1));
      chk("grant1_tx", 36'(grants[1]), 36'(2));
      chk("grant2_rx", 36'(grants[2]), 36'(1));
    end
    chk("both_rx_count", 36'(rx_got.size()), 36'(8));
    chk("both_tx_count", 36'(ft_tx_got.size()), 36'(8));

    // sink goes almost-full after the third word of a burst
    clear_logs();
    usb_txe_ni = 1'b1;
    for (int i = 0; i < 6; i++) ft_rx_q.push_back(32'h21 + 32'(i));
    drive();
    n = 0;
    while (rx_got.size() < 3 && n < 50) begin cycle(); n++; end
    chk("afull_setup", 36'(rx_got.size()), 36'(3));
    rx_afull_i = 1'b1;
    #1;
    chk("afull_rd_no", 36'(usb_rd_no), 36'(1));
    chk("afull_no_valid", 36'(rx_valid_o), 36'(0));
    for (int i = 0; i < 5; i++) cycle();
    chk("afull_hold_count", 36'(rx_got.size()), 36'(3));
    rx_afull_i = 1'b0;
    run_until_idle("afull_done", 200);
    chk("afull_count", 36'(rx_got.size()), 36'(6));
    for (int i = 0; i < rx_got.size() && i < 6; i++) chk("afull_data", 36'(rx_got[i]), 36'(32'h21 + 32'(i)));

    // asynchronous reset in the middle of a TX burst
    clear_logs();
    usb_txe_ni = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back({4'hF, 32'hB000_0000 + 32'(i)});
    drive();
    n = 0;
    while (state_o !== 3'd5 && n < 20) begin cycle(); n++; end
    cycle();
    chk("pre_reset_wr_no", 36'(usb_wr_no), 36'(0));
    #2 usb_rst_ni = 1'b0;
    #1;
    chk("async_wr_no", 36'(usb_wr_no), 36'(1));
    chk("async_data_oe", 36'(usb_data_oe), 36'(0));
    chk("async_rst_no", 36'(usb_rst_no), 36'(0));
    chk("async_tx_ready", 36'(tx_ready_o), 36'(0));
    cycle();
    cycle();
    usb_rst_ni = 1'b1;
    run_until_idle("post_reset_done", 200);
    chk("post_reset_count", 36'(ft_tx_got.size()), 36'(6));
    for (int i = 0; i < ft_tx_got.size() && i < 6; i++)
      chk("post_reset_data", ft_tx_got[i], {4'hF, 32'hB000_0000 + 32'(i)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ft601_bus_ctrl.md
Name: ft601_bus_ctrl

Overview:
Sequences the half-duplex FT601 245-synchronous FIFO bus on the USB clock domain.
- Arbitrates between the RX direction (FT601 to FPGA, into a stream) and the TX direction (stream to FT601).
- Inserts bus turnaround cycles and bounds each burst.
- Drives the split data/byte-enable/output-enable signals that the top level maps onto the IOBUFs.
- Also sequences the FT601 reset release after the controller leaves reset.

Parameters:
MaxBurst, 256, maximum words per burst before control is re-arbitrated (1..1024).
RstHoldCycles, 16, cycles usb_rst_no is held low after usb_rst_ni deasserts (>=1).

Ports:
usb_clk_i  in  1  FT601 clock; all logic on rising edge
usb_rst_ni  in  1  asynchronous active-low reset
usb_data_i  in  32  FT601 data bus input
usb_data_o  out  32  data driven during TX
usb_data_oe  out  1  data bus output enable
usb_be_o  out  4  byte enables during TX
usb_be_oe  out  1  byte-enable output enable
usb_rxf_ni  in  1  FT601 RX data available, active low
usb_txe_ni  in  1  FT601 TX space available, active low
usb_rd_no  out  1  read strobe, active low
usb_wr_no  out  1  write strobe, active low
usb_oe_no  out  1  FT601 output enable, active low
usb_siwu_no  out  1  tied 1
usb_rst_no  out  1  FT601 reset, active low
rx_valid_o  out  1  RX word present (no ready; sink must accept)
rx_data_o  out  32  RX word
rx_afull_i  in  1  RX sink cannot accept more words
tx_valid_i  in  1  TX word offered
tx_data_i  in  32  TX word
tx_be_i  in  4  TX byte enables
tx_ready_o  out  1  TX word consumed this cycle
busy_o  out  1  state != IDLE
state_o  out  3  encoded state, for debug

Behaviour:
- Reset (async assert): state=RESET, hold counter=0, burst counter=0, last_dir=TX.
  - Outputs at reset: usb_rd_no=usb_wr_no=usb_oe_no=1, usb_data_oe=usb_be_oe=0, usb_data_o=0, usb_be_o=0, usb_rst_no=0, usb_siwu_no=1, rx_valid_o=0, tx_ready_o=0, busy_o=1.
  - Reset asserted mid-burst aborts the burst immediately; no partial handshake completes.
- The state register is clocked. FT601 strobes/enables and stream handshakes are combinational from state and the current inputs.
- State encodings: RESET=0, IDLE=1, RX_OE=2, RX_BURST=3, RX_END=4, TX_BURST=5, TURN=6.
- RESET: usb_rst_no=0. Counts RstHoldCycles cycles, then goes to IDLE. usb_rst_no=1 from IDLE onward.
- IDLE:
  - rx_ok = !usb_rxf_ni && !rx_afull_i.
  - tx_ok = !usb_txe_ni && tx_valid_i.
  - If only one is true, grant it. If both, grant the direction opposite last_dir.
  - Grant RX: go to RX_OE, last_dir=RX. Grant TX: go to TX_BURST, last_dir=TX. Burst counter cleared on grant.
- RX_OE: usb_oe_no=0, usb_rd_no=1 for one cycle (turnaround), then RX_BURST.
- RX_BURST:
  - Outputs: usb_oe_no=0; usb_rd_no = rx_afull_i (low unless the sink is full).
  - A word transfers when !usb_rxf_ni && !rx_afull_i. That cycle: rx_valid_o=1, rx_data_o=usb_data_i, burst counter +1.
  - Exit to RX_END when usb_rxf_ni=1, rx_afull_i=1, or the counter reaches MaxBurst (the word completing the count is transferred).
- RX_END: usb_rd_no=1, usb_oe_no=1, then TURN.
- TX_BURST:
  - Outputs: usb_data_oe=usb_be_oe=1, usb_data_o=tx_data_i, usb_be_o=tx_be_i.
  - usb_wr_no = !(tx_valid_i && !usb_txe_ni).
  - tx_ready_o = !usb_txe_ni, asserted only in this state.
  - A word transfers when tx_valid_i && tx_ready_o; burst counter +1.
  - Exit to TURN when usb_txe_ni=1, tx_valid_i=0, or the counter reaches MaxBurst.
- TURN: all strobes high, data_oe=0 for one cycle, then IDLE. Guarantees >=1 undriven cycle between directions.
- usb_data_oe and usb_oe_no are never active in the same cycle.
- rx_valid_o is never asserted while rx_afull_i=1.
- Burst counter is $clog2(MaxBurst+1) bits and saturates at MaxBurst.

Test Plan:
- Reset release, RstHoldCycles=16: usb_rst_no low exactly 16 cycles after usb_rst_ni rises, then high; state goes RESET->IDLE, all strobes high.
- RX only, usb_rxf_ni low for 10 words 0x1..0xA: oe_no falls one cycle before rd_no; rx_valid_o pulses 10 times with data 1..10; then RX_END->TURN->IDLE, 3 cycles with no strobe.
- TX burst with MaxBurst=4 and 6 words queued: 4 words with wr_no low; TURN; second grant (no RX pending) transfers the remaining 2; tx_be_i appears on usb_be_o with usb_be_oe=1.
- RX and TX both pending continuously: grants alternate RX, TX, RX (first RX since last_dir resets to TX); never data_oe=1 with oe_no=0.
- rx_afull_i asserted mid-RX burst after word 3: rd_no rises the same cycle, no rx_valid_o, exit RX_END; no lost or duplicated words after afull drops.
- usb_rst_ni pulsed low during TX_BURST: wr_no=1, data_oe=0, usb_rst_no=0 immediately, without waiting for a clock edge.
